// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - screen encodings and default button geometry for the menu controller
package vga_pkg;

  localparam logic [4:0] SB_START  = 5'b00001;
  localparam logic [4:0] SB_SELECT = 5'b00010;
  localparam logic [4:0] SB_GAME   = 5'b00100;
  localparam logic [4:0] SB_END    = 5'b01000;
  localparam logic [4:0] SB_PULSE  = 5'b10000;

  typedef enum logic [4:0] {
    S_START  = SB_START,
    S_SELECT = SB_SELECT,
    S_GAME   = SB_GAME,
    S_END    = SB_END,
    S_PULSE  = SB_PULSE
  } screen_t;

  localparam int DEF_N_BTN     = 2;
  localparam int DEF_BTN_X0    = 256;
  localparam int DEF_BTN_Y0    = 200;
  localparam int DEF_BTN_W     = 128;
  localparam int DEF_BTN_H     = 48;
  localparam int DEF_BTN_PITCH = 100;

endpackage

// File: rtl/rect_hit.sv
// rtl/rect_hit.sv - inclusive point-in-rectangle test for one button
module rect_hit #(
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter int W  = 1,
  parameter int H  = 1
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic        o_hit
);

  // One extra bit so the far edges never wrap near the top of the 12-bit range.
  localparam logic [12:0] X_LO = 13'(X0);
  localparam logic [12:0] X_HI = 13'(X0 + W);
  localparam logic [12:0] Y_LO = 13'(Y0);
  localparam logic [12:0] Y_HI = 13'(Y0 + H);

  logic [12:0] w_x;
  logic [12:0] w_y;

  assign w_x   = {1'b0, i_x};
  assign w_y   = {1'b0, i_y};
  assign o_hit = (w_x >= X_LO) && (w_x <= X_HI) && (w_y >= Y_LO) && (w_y <= Y_HI);

endmodule

// File: rtl/menu_screen_ctrl.sv
// rtl/menu_screen_ctrl.sv - mouse-driven menu screen sequencer with game-reset pulse
module menu_screen_ctrl
  import vga_pkg::*;
#(
  parameter int N_BTN       = DEF_N_BTN,
  parameter int BTN_X0      = DEF_BTN_X0,
  parameter int BTN_Y0      = DEF_BTN_Y0,
  parameter int BTN_W       = DEF_BTN_W,
  parameter int BTN_H       = DEF_BTN_H,
  parameter int BTN_PITCH   = DEF_BTN_PITCH,
  parameter int RST_LEN     = 4,
  parameter int END_TIMEOUT = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      MouseLeft,
  input  logic                                      MouseRight,
  input  logic [11:0]                               xpos,
  input  logic [11:0]                               ypos,
  input  logic [1:0]                                resoult,
  output logic [4:0]                                state_bin,
  output logic                                      rst_sys,
  output logic [$clog2((N_BTN > 2) ? N_BTN : 2)-1:0] mode_sel,
  output logic [N_BTN-1:0]                          hover,
  output logic [1:0]                                result_q
);

  localparam int IDX_W  = $clog2((N_BTN > 2) ? N_BTN : 2);
  localparam int PCNT_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam int TCNT_W = (END_TIMEOUT > 1) ? $clog2(END_TIMEOUT) : 1;
  localparam logic [PCNT_W-1:0] P_LAST = PCNT_W'(RST_LEN - 1);
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'((END_TIMEOUT > 0) ? END_TIMEOUT - 1 : 0);

  logic [N_BTN-1:0] w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_any;
  logic             w_lpress;
  logic             w_rpress;

  screen_t          r_state, w_state_nxt;
  screen_t          r_target, w_target_nxt;
  logic [PCNT_W-1:0] r_pcnt, w_pcnt_nxt;
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic [IDX_W-1:0] r_mode_sel, w_mode_nxt;
  logic [1:0]       r_result_q, w_result_nxt;
  logic [N_BTN-1:0] r_hover;
  logic             r_ml_q;
  logic             r_mr_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    rect_hit #(
      .X0(BTN_X0),
      .Y0(BTN_Y0 + g * BTN_PITCH),
      .W (BTN_W),
      .H (BTN_H)
    ) u_hit (
      .i_x  (xpos),
      .i_y  (ypos),
      .o_hit(w_hit[g])
    );
  end

  // Scan downward so the lowest hit index wins on overlap.
  always_comb begin
    w_hit_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDX_W'(i);
    end
  end

  assign w_any    = |w_hit;
  assign w_lpress = MouseLeft & ~r_ml_q;
  assign w_rpress = MouseRight & ~r_mr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_START;
      r_target   <= S_START;
      r_pcnt     <= '0;
      r_tcnt     <= '0;
      r_mode_sel <= '0;
      r_result_q <= '0;
      r_hover    <= '0;
      r_ml_q     <= MouseLeft;
      r_mr_q     <= MouseRight;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_mode_sel <= w_mode_nxt;
      r_result_q <= w_result_nxt;
      r_hover    <= w_hit;
      r_ml_q     <= MouseLeft;
      r_mr_q     <= MouseRight;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_pcnt_nxt   = '0;
    w_tcnt_nxt   = '0;
    w_mode_nxt   = r_mode_sel;
    w_result_nxt = r_result_q;
    case (r_state)
      S_START: begin
        if (w_lpress && w_any) begin
          w_state_nxt = S_SELECT;
          w_mode_nxt  = w_hit_idx;
        end
      end
      S_SELECT: begin
        if (w_rpress) w_state_nxt = S_GAME;
      end
      S_GAME: begin
        if (w_rpress || (resoult != 2'b00)) begin
          w_state_nxt  = S_END;
          w_result_nxt = resoult;
        end
      end
      S_END: begin
        if (w_lpress && w_any && (w_hit_idx == IDX_W'(0))) begin
          w_state_nxt  = S_PULSE;
          w_target_nxt = S_SELECT;
        end else if (w_lpress && w_any && (w_hit_idx == IDX_W'(1))) begin
          w_state_nxt  = S_PULSE;
          w_target_nxt = S_START;
        end else if (!w_lpress && (END_TIMEOUT > 0)) begin
          if (r_tcnt == T_LAST) begin
            w_state_nxt  = S_PULSE;
            w_target_nxt = S_START;
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      S_PULSE: begin
        if (r_pcnt == P_LAST) w_state_nxt = r_target;
        else                  w_pcnt_nxt  = r_pcnt + 1'b1;
      end
      default: w_state_nxt = S_START;
    endcase
  end

  assign state_bin = r_state;
  assign rst_sys   = (r_state == S_PULSE);
  assign mode_sel  = r_mode_sel;
  assign hover     = r_hover;
  assign result_q  = r_result_q;

endmodule

// File: doc/menu_screen_ctrl.md
MENU_SCREEN_CTRL -- requirements
Module: menu_screen_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 2: number of clickable buttons per menu screen (2..8).
REQ-002 SHALL have parameter BTN_X0, default 256: left x edge of every button.
REQ-003 SHALL have parameter BTN_Y0, default 200: top y edge of button 0.
REQ-004 SHALL have parameters BTN_W and BTN_H, defaults 128 and 48: button width and height in pixels.
REQ-005 SHALL have parameter BTN_PITCH, default 100: vertical offset between consecutive buttons.
REQ-006 SHALL have parameter RST_LEN, default 4: rst_sys pulse length in cycles (>=1).
REQ-007 SHALL have parameter END_TIMEOUT, default 0: END-screen idle cycles before auto-return; 0 disables it.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have ports MouseLeft and MouseRight, input, 1 bit each: mouse button levels.
REQ-011 SHALL have ports xpos and ypos, input, 12 bits each: cursor position.
REQ-012 SHALL have port resoult, input, 2 bits: game outcome; 00 none, 01/10 player win, 11 draw.
REQ-013 SHALL have port state_bin, output, 5 bits: one-hot screen (START=00001, SELECT=00010, GAME=00100, END=01000, PULSE=10000).
REQ-014 SHALL have port rst_sys, output, 1 bit: game-logic reset pulse.
REQ-015 SHALL have port mode_sel, output, IDX_W=$clog2(max(N_BTN,2)) bits: button index chosen on START.
REQ-016 SHALL have port hover, output, N_BTN bits: registered per-button cursor-inside flags.
REQ-017 SHALL have port result_q, output, 2 bits: resoult latched on leaving GAME.

Function
REQ-018 SHALL treat button i as hit when BTN_X0<=xpos<=BTN_X0+BTN_W and BTN_Y0+i*BTN_PITCH<=ypos<=BTN_Y0+i*BTN_PITCH+BTN_H, with all edges inclusive and 13-bit compare arithmetic (no wrap).
REQ-019 SHALL, when rectangles overlap, give priority to the lowest hit index.
REQ-020 SHALL register MouseLeft and MouseRight each cycle; a press is the level being 1 now while the registered value is 0, so one physical press yields exactly one press event.
REQ-021 SHALL evaluate transitions on the clk edge where the press is detected, using the combinational hit of the same cycle; state_bin shows the new state after that edge (latency 1).
REQ-022 In START, SHALL go to SELECT on a left press on any button and load mode_sel with that button's index; a left press outside every button has no effect.
REQ-023 In SELECT, SHALL go to GAME on a right press.
REQ-024 In GAME, SHALL go to END on a right press or when resoult!=00, latching result_q<=resoult in the same edge (00 on an abort).
REQ-025 In GAME, when a right press and resoult!=00 coincide, SHALL go to END with result_q<=resoult.
REQ-026 In END, a left press on button 0 SHALL go to PULSE with target SELECT, and a left press on button 1 SHALL go to PULSE with target START; other buttons SHALL be ignored.
REQ-027 In END, when END_TIMEOUT>0, SHALL count cycles with no left press and, when the count reaches END_TIMEOUT, go to PULSE with target START; any left press SHALL clear the counter.
REQ-028 In PULSE, SHALL hold rst_sys=1 for exactly RST_LEN cycles, then go to the target state with rst_sys=0; mouse events are ignored during PULSE.
REQ-029 Outside PULSE, rst_sys SHALL be 0.
REQ-030 SHALL update hover with a one-cycle registered copy of the hit vector, in every state.

Reset
REQ-031 SHALL, on rst, set state to START, state_bin=00001, rst_sys=0, mode_sel=0, result_q=00, hover=0, and clear the pulse and timeout counters.
REQ-032 SHALL, on rst, load the edge registers with the current MouseLeft/MouseRight levels, so a button held through reset release produces no press.
REQ-033 SHALL abort PULSE immediately on a reset mid-operation, with rst_sys=0 in the next cycle.

Structure
REQ-034 SHALL declare the screen_t enum and the one-hot encodings in vga_pkg; button geometry defaults SHALL come from vga_pkg constants.
REQ-035 SHALL place the per-button comparison in a sub-module rect_hit (combinational; one instance per button via generate).
REQ-036 SHALL keep the pulse and timeout counters $clog2-sized from RST_LEN and END_TIMEOUT.

Verification
REQ-037 Scenario: reset with MouseLeft held, then cursor moved into button 0 -> state remains START, because no press event occurs until release and re-press.
REQ-038 Scenario: N_BTN=3, left press at (BTN_X0+BTN_W, BTN_Y0+2*BTN_PITCH) -> SELECT next cycle with mode_sel=2 (inclusive corner).
REQ-039 Scenario: in GAME, right press and resoult=10 in the same cycle -> state_bin=01000 and result_q=10.
REQ-040 Scenario: in END, left press on button 1 with RST_LEN=4 -> rst_sys high for exactly 4 cycles, then state_bin=00001.
REQ-041 Scenario: END_TIMEOUT=10 with no clicks -> PULSE entered 10 cycles after END entry; a click at cycle 5 restarts the count.
REQ-042 Scenario: assert rst during the second PULSE cycle -> the next cycle shows rst_sys=0 and state_bin=00001.
